uart_line_echo: RTL and testbench
=================================

Name: uart_line_echo

Overview:
Line-oriented byte handler that sits directly downstream of the uart RX FIFO and upstream of the uart TX FIFO.
- Pops received bytes from the uart's rd_uart/rx_empty/r_data side and assembles them into a line buffer, with backspace editing.
- On carriage return it writes the whole line back through the uart's wr_uart/tx_full/w_data side, followed by CR LF.
- Forms the line-editing front end of the echo/command console.

Parameters:
AW, 4, line buffer address bits; buffer holds 2^AW bytes (default 16)
UPCASE, 0, 1 = convert 'a'..'z' (0x61..0x7A) to 'A'..'Z' on transmit; 0 = bytes sent unchanged

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx_empty  in  1  uart RX FIFO empty flag
r_data  in  8  uart RX FIFO head byte, valid whenever rx_empty=0 (first-word fall-through)
rd_uart  out  1  pop strobe to uart RX FIFO
tx_full  in  1  uart TX FIFO full flag
w_data  out  8  byte to uart TX FIFO
wr_uart  out  1  push strobe to uart TX FIFO
busy  out  1  1 while in SEND, SEND_CR or SEND_LF
line_len  out  AW+1  bytes currently held in the buffer (0..2^AW)
overflow  out  1  sticky: at least one data byte was dropped in the current line
line_done  out  1  one-cycle pulse on the cycle the trailing LF is pushed

Behaviour:
- One clock; reset is synchronous and active-low.
- All state updates on rising clk edge. reset=0 at an edge: state=COLLECT, count=0, overflow=0, send index=0.
- While reset=0, rd_uart=0, wr_uart=0 and line_done=0, regardless of rx_empty/tx_full. Buffer contents need no reset.
- Strobe and data outputs are combinational from state and flags, so the FIFO full/empty flags are obeyed in the same cycle:
  - rd_uart = (state==COLLECT) & ~rx_empty
  - wr_uart = (state in SEND/SEND_CR/SEND_LF) & ~tx_full
  - w_data = 0x00 in COLLECT
- Back-to-back pops and pushes are allowed on every cycle.
- States: COLLECT, SEND, SEND_CR, SEND_LF.
- COLLECT. Every cycle with rd_uart=1, r_data is consumed and classified:
  - 0x0D (CR): to SEND (to SEND_CR if count=0); send index=0; CR is not stored.
  - 0x0A (LF): discarded (tolerates CRLF senders).
  - 0x08 or 0x7F (backspace): count-=1 if count>0, else no effect; overflow unchanged.
  - Any other byte, count<2^AW: buf[count]=r_data; count+=1.
  - Any other byte, count==2^AW: byte discarded; overflow=1.
- SEND:
  - w_data = buf[idx], upper-cased if UPCASE=1.
  - On wr_uart=1: idx+=1. If idx==count-1, go to SEND_CR.
  - tx_full=1 stalls in place; idx and w_data are held.
- SEND_CR: w_data=0x0D; on wr_uart=1 go to SEND_LF.
- SEND_LF: w_data=0x0A. On wr_uart=1:
  - line_done=1 that cycle.
  - At the edge: count=0, overflow=0, state=COLLECT.
- No RX byte is popped while busy=1; incoming bytes queue in the uart RX FIFO.
- line_len = count at all times; it holds the line length throughout sending and reads 0 after line_done.
- Full buffer (count=2^AW): idx range 0..2^AW-1; the idx counter is AW+1 bits so there is no wrap.
- Reset during any state aborts immediately. No partial CR/LF is sent after reset; the next cycle is COLLECT with an empty buffer.

Test Plan:
- RX bytes 'h','i',0x0D, tx_full=0, UPCASE=0 -> TX pushes 0x68,0x69,0x0D,0x0A on 4 consecutive cycles; line_len=2 during send; line_done pulses with 0x0A; line_len=0 after.
- UPCASE=1, RX 'a','Z','q',0x0D -> TX 0x41,0x5A,0x51,0x0D,0x0A. Also RX lone 0x0D -> TX 0x0D,0x0A only.
- RX 'a','b',0x08,'c',0x7F,0x7F,0x7F,'d',0x0D,0x0A -> TX 'd',0x0D,0x0A. The extra backspaces and trailing LF have no effect; the LF is popped and dropped.
- AW=4, RX 20 bytes 0x30..0x43 then 0x0D -> overflow=1 after byte 17; TX 0x30..0x3F,0x0D,0x0A; overflow=0 after line_done.
- Backpressure: hold tx_full=1 for 5 cycles mid-line; bytes also arriving on RX -> wr_uart=0 and w_data stable while stalled; no byte lost or duplicated; rd_uart=0 throughout SEND; queued RX bytes are read after line_done.
- Assert reset=0 for one cycle during SEND of a 10-byte line -> wr_uart=0 next cycle, busy=0, line_len=0, no CR/LF emitted; the next line echoes correctly.

Source files
------------

// File: rtl/uart_line_echo.sv
// uart_line_echo: line editor between the uart RX FIFO and the uart TX FIFO.
// It collects bytes into a line buffer and handles backspace. On CR it echoes
// the buffered line back, followed by CR LF. The FIFO strobes are combinational
// from state and flags, so empty/full are honoured in the same cycle.
module uart_line_echo #(
  parameter int AW     = 4,
  parameter bit UPCASE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_empty,
  input  logic [7:0]    r_data,
  output logic          rd_uart,
  input  logic          tx_full,
  output logic [7:0]    w_data,
  output logic          wr_uart,
  output logic          busy,
  output logic [AW:0]   line_len,
  output logic          overflow,
  output logic          line_done
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [7:0]  CH_CR = 8'h0D;
  localparam logic [7:0]  CH_LF = 8'h0A;
  localparam logic [7:0]  CH_BS = 8'h08;
  localparam logic [7:0]  CH_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SEND,
    ST_SEND_CR,
    ST_SEND_LF
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [AW:0] r_count;
  logic [AW:0] r_idx;
  logic        r_ovf;
  logic [7:0]  r_buf [0:(1<<AW)-1];

  logic        w_rd;
  logic        w_wr;
  logic        w_busy;
  logic        w_is_cr;
  logic        w_is_lf;
  logic        w_is_bs;
  logic        w_is_data;
  logic        w_full;
  logic        w_store;
  logic        w_last;
  logic [AW:0] w_cnt_m1;
  logic [7:0]  w_byte;
  logic [7:0]  w_tx_byte;

  // Strobes are gated by reset so nothing moves through the FIFOs while held.
  assign w_busy    = (r_state != ST_COLLECT);
  assign w_rd      = reset & (r_state == ST_COLLECT) & ~rx_empty;
  assign w_wr      = reset & w_busy & ~tx_full;

  assign w_is_cr   = (r_data == CH_CR);
  assign w_is_lf   = (r_data == CH_LF);
  assign w_is_bs   = (r_data == CH_BS) | (r_data == CH_DEL);
  assign w_is_data = ~w_is_cr & ~w_is_lf & ~w_is_bs;
  assign w_full    = (r_count == DEPTH);
  assign w_store   = w_rd & w_is_data & ~w_full;

  // Index is one bit wider than the buffer address, so a full line never wraps.
  assign w_cnt_m1  = r_count - 1'b1;
  assign w_last    = (r_idx == w_cnt_m1);
  assign w_byte    = r_buf[r_idx[AW-1:0]];

  // Optional lower-to-upper case mapping applied only on the way out.
  always_comb begin
    w_tx_byte = w_byte;
    if ((UPCASE != 1'b0) && (w_byte >= 8'h61) && (w_byte <= 8'h7A))
      w_tx_byte = w_byte - 8'h20;
  end

  // Next-state logic: CR on an empty line skips straight to the CR/LF tail.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: begin
        if (w_rd && w_is_cr)
          w_state_nxt = (r_count == '0) ? ST_SEND_CR : ST_SEND;
      end
      ST_SEND: begin
        if (w_wr && w_last)
          w_state_nxt = ST_SEND_CR;
      end
      ST_SEND_CR: begin
        if (w_wr)
          w_state_nxt = ST_SEND_LF;
      end
      ST_SEND_LF: begin
        if (w_wr)
          w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  // Outgoing byte select; zero while collecting.
  always_comb begin
    w_data = 8'h00;
    case (r_state)
      ST_SEND:    w_data = w_tx_byte;
      ST_SEND_CR: w_data = CH_CR;
      ST_SEND_LF: w_data = CH_LF;
      default:    w_data = 8'h00;
    endcase
  end

  // State register; reset aborts any send in progress.
  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= ST_COLLECT;
    else
      r_state <= w_state_nxt;
  end

  // Line length, send index and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_rd) begin
            if (w_is_cr)
              r_idx <= '0;
            else if (w_is_bs) begin
              if (r_count != '0)
                r_count <= w_cnt_m1;
            end else if (w_is_data) begin
              if (w_full)
                r_ovf <= 1'b1;
              else
                r_count <= r_count + 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (w_wr)
            r_idx <= r_idx + 1'b1;
        end
        ST_SEND_LF: begin
          if (w_wr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_store)
      r_buf[r_count[AW-1:0]] <= r_data;
  end

  assign rd_uart   = w_rd;
  assign wr_uart   = w_wr;
  assign busy      = w_busy;
  assign line_len  = r_count;
  assign overflow  = r_ovf;
  assign line_done = w_wr & (r_state == ST_SEND_LF);

endmodule

// File: tb/tb_uart_line_echo.sv
// Bench for uart_line_echo: a queue-level line model checked every cycle,
// plus literal expectations on the captured TX byte streams.
module tb_uart_line_echo;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       tx_full;
  logic       rd0, wr0, busy0, ovf0, done0;
  logic       rd1, wr1, busy1, ovf1, done1;
  logic [7:0] wd0, wd1;
  logic [4:0] len0, len1;

  uart_line_echo #(.AW(4), .UPCASE(1'b0)) u0 (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd0),
    .tx_full(tx_full), .w_data(wd0), .wr_uart(wr0), .busy(busy0), .line_len(len0),
    .overflow(ovf0), .line_done(done0));

  uart_line_echo #(.AW(4), .UPCASE(1'b1)) u1 (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd1),
    .tx_full(tx_full), .w_data(wd1), .wr_uart(wr1), .busy(busy1), .line_len(len1),
    .overflow(ovf1), .line_done(done1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   nchk = 0;
  int   nerr = 0;
  int   cycle = 0;
  bq_t  rxq;                 // uart RX FIFO contents
  bq_t  line_m;              // model: bytes held in the line
  bq_t  txq_m;               // model: bytes still to be pushed
  logic ovf_m = 1'b0;
  logic m_rd;
  logic s_rd;
  logic rst_v = 1'b0;
  logic stall = 1'b0;
  bq_t  s0, s1, lq, dq;      // captured pushes: data (both DUTs), line_len, line_done
  int   cyc[$];
  int   npop = 0;
  int   ovf_pop = -1;
  int   ovf_len = -1;

  function automatic logic [7:0] upc(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_seq(input string nm, input bq_t got, input bq_t exp);
    int bad = -1;
    nchk++;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (bad < 0 && got[i] != exp[i]) bad = i;
    if (bad < 0 && got.size() != exp.size()) bad = (got.size() < exp.size()) ? got.size() : exp.size();
    if (bad >= 0) begin
      nerr++;
      $display("FAIL %s: got %0d bytes, expected %0d; first difference at index %0d (got %0h, expected %0h)",
               nm, got.size(), exp.size(), bad,
               (bad < got.size()) ? got[bad] : 8'hxx, (bad < exp.size()) ? exp[bad] : 8'hxx);
    end
  endtask

  task automatic drive();
    reset    = rst_v;
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    tx_full  = stall;
  endtask

  // One clock: drive inputs, compare on negedge, advance model at posedge.
  task automatic tick();
    logic busy_m, exp_wr, exp_done;
    logic [7:0] exp_wd;
    drive();
    @(negedge clk);
    busy_m   = (txq_m.size() != 0);
    m_rd     = reset && !busy_m && (rxq.size() != 0);
    exp_wr   = reset && busy_m && !tx_full;
    exp_wd   = busy_m ? txq_m[0] : 8'h00;
    exp_done = exp_wr && (txq_m.size() == 1);
    chk("rd_uart", rd0, m_rd);           chk("rd_uart_up", rd1, m_rd);
    chk("wr_uart", wr0, exp_wr);         chk("wr_uart_up", wr1, exp_wr);
    chk("w_data", wd0, exp_wd);          chk("w_data_up", wd1, upc(exp_wd));
    chk("line_done", done0, exp_done);   chk("line_done_up", done1, exp_done);
    chk("busy", busy0, busy_m);          chk("busy_up", busy1, busy_m);
    chk("line_len", len0, line_m.size()); chk("line_len_up", len1, line_m.size());
    chk("overflow", ovf0, ovf_m);        chk("overflow_up", ovf1, ovf_m);
    if (ovf0 && ovf_pop < 0) begin
      ovf_pop = npop;
      ovf_len = len0;
    end
    if (rd0) npop++;
    if (wr0) begin
      s0.push_back(wd0); lq.push_back(8'(len0)); dq.push_back(8'(done0)); cyc.push_back(cycle);
    end
    if (wr1) s1.push_back(wd1);
    s_rd = rd0;
    @(posedge clk);
    cycle++;
    if (!reset) begin
      line_m = {}; txq_m = {}; ovf_m = 1'b0;
    end else if (txq_m.size() != 0) begin
      if (!tx_full) begin
        void'(txq_m.pop_front());
        if (txq_m.size() == 0) begin
          line_m = {}; ovf_m = 1'b0;
        end
      end
    end else if (m_rd) begin
      case (rxq[0])
        8'h0D: begin
          txq_m = line_m; txq_m.push_back(8'h0D); txq_m.push_back(8'h0A);
        end
        8'h0A: ;
        8'h08, 8'h7F: if (line_m.size() != 0) void'(line_m.pop_back());
        default: if (line_m.size() < 16) line_m.push_back(rxq[0]); else ovf_m = 1'b1;
      endcase
    end
    if (s_rd && rxq.size() != 0) void'(rxq.pop_front());
    #1;
  endtask

  task automatic push_bytes(input bq_t b);
    foreach (b[i]) rxq.push_back(b[i]);
  endtask

  task automatic clear_caps();
    s0 = {}; s1 = {}; lq = {}; dq = {}; cyc = {};
  endtask

  task automatic run_idle(input string nm);
    int n = 0;
    do begin
      tick(); n++;
    end while ((rxq.size() != 0 || txq_m.size() != 0 || busy0) && n < 400);
    chk({nm, "_timeout"}, (n < 400) ? 1 : 0, 1);
  endtask

  task automatic wait_stream(input string nm, input int cnt);
    int n = 0;
    while (s0.size() < cnt && n < 200) begin
      tick(); n++;
    end
    chk({nm, "_timeout"}, (s0.size() >= cnt) ? 1 : 0, 1);
  endtask

  initial begin
    bq_t exp;
    // Reset phase: RX holds a byte and TX has room, yet no strobe may fire.
    reset = 1'b0; rx_empty = 1'b0; r_data = 8'h41; tx_full = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_rd_uart", rd0, 0);
    chk("reset_wr_uart", wr0, 0);
    chk("reset_line_done", done0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_line_len", len0, 0);
    chk("reset_overflow", ovf0, 0);
    rst_v = 1'b1;

    // Short line, echoed on consecutive cycles.
    clear_caps();
    push_bytes('{8'h68, 8'h69, 8'h0D});
    run_idle("hi");
    exp = '{8'h68, 8'h69, 8'h0D, 8'h0A};
    check_seq("hi_stream", s0, exp);
    chk("hi_consecutive", (cyc.size() == 4) ? cyc[3] - cyc[0] : -1, 3);
    chk("hi_len_first", (lq.size() > 0) ? lq[0] : -1, 2);
    chk("hi_len_cr", (lq.size() > 2) ? lq[2] : -1, 2);
    exp = '{8'h00, 8'h00, 8'h00, 8'h01};
    check_seq("hi_line_done", dq, exp);
    chk("hi_len_after", len0, 0);

    // Upper-case mapping only on the UPCASE instance.
    clear_caps();
    push_bytes('{8'h61, 8'h5A, 8'h71, 8'h0D});
    run_idle("upc");
    exp = '{8'h41, 8'h5A, 8'h51, 8'h0D, 8'h0A};
    check_seq("upc_stream_up", s1, exp);
    exp = '{8'h61, 8'h5A, 8'h71, 8'h0D, 8'h0A};
    check_seq("upc_stream_plain", s0, exp);

    // Lone CR: only the CR LF tail.
    clear_caps();
    push_bytes('{8'h0D});
    run_idle("lone_cr");
    exp = '{8'h0D, 8'h0A};
    check_seq("lone_cr_stream", s1, exp);

    // Backspace editing, excess backspaces and a trailing LF.
    clear_caps();
    push_bytes('{8'h61, 8'h62, 8'h08, 8'h63, 8'h7F, 8'h7F, 8'h7F, 8'h64, 8'h0D, 8'h0A});
    run_idle("bs");
    exp = '{8'h64, 8'h0D, 8'h0A};
    check_seq("bs_stream", s0, exp);
    chk("bs_rx_drained", rxq.size(), 0);
    chk("bs_len_after", len0, 0);

    // Overflow: 20 data bytes into a 16-byte buffer.
    clear_caps();
    ovf_pop = -1; ovf_len = -1; npop = 0;
    for (int i = 0; i < 20; i++) rxq.push_back(8'(8'h30 + i));
    rxq.push_back(8'h0D);
    run_idle("ovf");
    chk("ovf_after_byte", ovf_pop, 17);
    chk("ovf_len_full", ovf_len, 16);
    exp = {};
    for (int i = 0; i < 16; i++) exp.push_back(8'(8'h30 + i));
    exp.push_back(8'h0D); exp.push_back(8'h0A);
    check_seq("ovf_stream", s0, exp);
    chk("ovf_cleared", ovf0, 0);

    // Backpressure mid-line with RX traffic arriving meanwhile.
    clear_caps();
    push_bytes('{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D});
    wait_stream("bp", 2);
    stall = 1'b1;
    push_bytes('{8'h78, 8'h79, 8'h0D});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_wd_held", wd0, 8'h43);
      chk("bp_wr_low", wr0, 0);
      chk("bp_rd_low", rd0, 0);
    end
    stall = 1'b0;
    run_idle("bp");
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A, 8'h78, 8'h79, 8'h0D, 8'h0A};
    check_seq("bp_stream", s0, exp);

    // Reset in the middle of sending a 10-byte line.
    clear_caps();
    for (int i = 0; i < 10; i++) rxq.push_back(8'(8'h61 + i));
    rxq.push_back(8'h0D);
    wait_stream("rst", 3);
    rst_v = 1'b0;
    tick();
    rst_v = 1'b1;
    chk("rst_busy", busy0, 0);
    chk("rst_line_len", len0, 0);
    chk("rst_wr_uart", wr0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("rst_no_tail", s0.size(), 3);
    clear_caps();
    push_bytes('{8'h6F, 8'h6B, 8'h0D});
    run_idle("rst_next");
    exp = '{8'h6F, 8'h6B, 8'h0D, 8'h0A};
    check_seq("rst_next_stream", s0, exp);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
